alu_ctrl_fsm: RTL

Upstream sequencer for the 6-bit `ALU`. It accepts one operation per valid/ready handshake and drives registered operands and opcode into the ALU. It captures the ALU's `R` and `alu_flag` one cycle later and presents them on a valid/ready result port with backpressure. It also counts completed operations and flags unsupported opcodes.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_ctrl_fsm_if.sv | 48 ++++
 rtl/alu_ctrl_fsm.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: controller states, opcode
// encodings and the default datapath width of the ALU it drives.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } alu_ctrl_state_t;

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Bundle of the request port, the ALU-facing operand/result signals and the
// result port of alu_ctrl_fsm.
//
// Handshake rule for both the request (in_*) and the result (out_*) port:
// a transfer happens on a rising clk edge where valid and ready are both 1;
// once valid is raised the payload holds until that edge, and ready never
// depends combinationally on valid.
//
// The slave modport is the controller; the master modport is the parent that
// issues requests, consumes results and hosts the ALU.
interface alu_ctrl_fsm_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_chain;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_flag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_flag;
  logic             out_err;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_chain, alu_r, alu_flag, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_r, out_flag,
           out_err, ops_done
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_chain, alu_r, alu_flag, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_r, out_flag,
           out_err, ops_done
  );

endinterface

// File: rtl/alu_ctrl_fsm.sv
// Sequencer in front of the ALU: accepts one request, holds the operands on
// alu_a/alu_b/alu_op for a full EXEC cycle, captures the ALU result and then
// offers it on the result port until the consumer takes it.
//
// Optional build macro ALU_CTRL_CHAIN_EN: when defined, a request with
// in_chain=1 uses the previous ALU result as operand A. When undefined,
// in_chain is ignored and no previous-result register exists.
module alu_ctrl_fsm
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  output alu_ctrl_state_t state_dbg,
  alu_ctrl_fsm_if.slave   bus
);

  alu_ctrl_state_t  state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] r_q;
  logic             flag_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_next;

`ifdef ALU_CTRL_CHAIN_EN
  logic [WIDTH-1:0] prev_q;

  // Chained requests take operand A from the last ALU result.
  always_comb begin
    a_next = bus.in_chain ? prev_q : bus.in_a;
  end

  // Previous-result register, refreshed at the end of every EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else if (state == EXEC) begin
      prev_q <= bus.alu_r;
    end
  end
`else
  wire unused_in_chain = bus.in_chain;

  // Without chaining operand A always comes straight from the request.
  always_comb begin
    a_next = bus.in_a;
  end
`endif

  // Controller FSM with all handshake and datapath outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      r_q         <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= a_next;
            b_q        <= bus.in_b;
            op_q       <= bus.in_op;
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // ALU saw stable operands all cycle; take its answer as-is.
          r_q         <= bus.alu_r;
          flag_q      <= bus.alu_flag;
          err_q       <= op_q[1];
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = r_q;
  assign bus.out_flag  = flag_q;
  assign bus.out_err   = err_q;
  assign bus.ops_done  = cnt_q;
  assign state_dbg     = state;

endmodule
